// File: rtl/i2c_byte_fifo.sv
// ---------------------------------------------------------------------------
// i2c_byte_fifo
//
// Synchronous byte FIFO that sits between the APB register block and the I2C
// byte engine. It is used twice: as the TX-FIFO (APB pushes, I2C engine
// pops) and as the RX-FIFO (I2C engine pushes, APB pops). Besides the head
// data byte it also provides the status byte read by the APB status register.
//
// Build option:
//   I2C_FIFO_FWFT_EN  when defined, data_o shows the head word combinationally
//                     (first-word-fall-through) and rd_en_i only acknowledges
//                     it. When undefined, data_o is loaded on each accepted
//                     pop and holds until the next one.
//
// Ports:
//   pclk_i     in   clock, all logic on the rising edge
//   preset_ni  in   asynchronous active-low reset
//   clear_i    in   synchronous flush; overrides push and pop
//   wr_en_i    in   push request (one per cycle)
//   data_i     in   push data
//   rd_en_i    in   pop request (one per cycle)
//   data_o     out  read data
//   status_o   out  {2'b0, underflow, overflow, almost_full, almost_empty,
//                    full, empty}; overflow/underflow are sticky
//   count_o    out  number of stored words, 0..2**ADDR_WIDTH
// ---------------------------------------------------------------------------
module i2c_byte_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AE_LEVEL   = 2,
  parameter int AF_LEVEL   = 14
) (
  input  logic                  pclk_i,
  input  logic                  preset_ni,
  input  logic                  clear_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [7:0]            status_o,
  output logic [ADDR_WIDTH:0]   count_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] C_AE    = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0] C_AF    = (ADDR_WIDTH+1)'(AF_LEVEL);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_empty;
  logic w_full;
  logic w_almost_empty;
  logic w_almost_full;
  logic w_rd_ok;
  logic w_wr_ok;

  assign w_empty        = (r_count == '0);
  assign w_full         = (r_count == C_DEPTH);
  assign w_almost_empty = (r_count <= C_AE);
  assign w_almost_full  = (r_count >= C_AF);

  // A pop only succeeds on a non-empty FIFO. A push into a full FIFO is
  // still accepted when a pop frees a slot on the same edge. Neither is
  // accepted while a flush is in progress.
  assign w_rd_ok = rd_en_i && !w_empty && !clear_i;
  assign w_wr_ok = wr_en_i && (!w_full || w_rd_ok) && !clear_i;

  // Storage is deliberately not reset so it maps onto plain RAM.
  always_ff @(posedge pclk_i) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clear_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Sticky error flags: only reset or flush clears them.
      if (wr_en_i && !w_wr_ok) begin
        r_overflow <= 1'b1;
      end
      // A pop on an empty FIFO is an underflow even if a push lands on
      // the same edge; the pushed word stays in the FIFO.
      if (rd_en_i && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

`ifdef I2C_FIFO_FWFT_EN
  // Head word is visible without a pop; the output reads 0 while empty.
  assign data_o = w_empty ? '0 : r_mem[r_rd_ptr];
`else
  logic [DATA_WIDTH-1:0] r_data;

  // Registered read: loaded only on an accepted pop, held otherwise.
  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      r_data <= '0;
    end else if (clear_i) begin
      r_data <= '0;
    end else if (w_rd_ok) begin
      r_data <= r_mem[r_rd_ptr];
    end
  end

  assign data_o = r_data;
`endif

  assign count_o  = r_count;
  assign status_o = {2'b00, r_underflow, r_overflow,
                     w_almost_full, w_almost_empty, w_full, w_empty};

endmodule

// File: tb/tb_i2c_byte_fifo.sv
module tb_i2c_byte_fifo;

  logic       pclk_i = 1'b0;
  logic       preset_ni;
  logic       clear_i;
  logic       wr_en_i;
  logic [7:0] data_i;
  logic       rd_en_i;
  logic [7:0] data_o;
  logic [7:0] status_o;
  logic [4:0] count_o;

  int errors = 0;
  int checks = 0;

  // Reference model: a queue holding the stored words in order.
  logic [7:0] q[$];
  logic       m_ov;
  logic       m_uf;
  logic [7:0] m_dout;

  always #5 pclk_i = ~pclk_i;

  i2c_byte_fifo dut (
    .pclk_i    (pclk_i),
    .preset_ni (preset_ni),
    .clear_i   (clear_i),
    .wr_en_i   (wr_en_i),
    .data_i    (data_i),
    .rd_en_i   (rd_en_i),
    .data_o    (data_o),
    .status_o  (status_o),
    .count_o   (count_o)
  );

  function automatic logic [7:0] exp_status();
    int n = q.size();
    return {2'b00, m_uf, m_ov, (n >= 14), (n <= 2), (n == 16), (n == 0)};
  endfunction

  function automatic logic [7:0] exp_data();
`ifdef I2C_FIFO_FWFT_EN
    return (q.size() != 0) ? q[0] : 8'h00;
`else
    return m_dout;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    m_ov   = 1'b0;
    m_uf   = 1'b0;
    m_dout = 8'h00;
  endtask

  task automatic model_edge(input logic wr, input logic rd, input logic clr,
                            input logic [7:0] d);
    logic rd_ok;
    logic wr_ok;
    if (clr) begin
      model_reset();
    end else begin
      rd_ok = rd && (q.size() > 0);
      wr_ok = wr && ((q.size() < 16) || rd_ok);
      if (rd && q.size() == 0) m_uf = 1'b1;
      if (wr && !wr_ok) m_ov = 1'b1;
      if (rd_ok) m_dout = q.pop_front();
      if (wr_ok) q.push_back(d);
    end
  endtask

  // Drives one clock cycle of stimulus and advances the model; outputs are
  // then sampled 1 ns after the edge by the caller.
  task automatic step(input logic wr, input logic rd, input logic clr,
                      input logic [7:0] d);
    wr_en_i = wr;
    rd_en_i = rd;
    clear_i = clr;
    data_i  = d;
    @(posedge pclk_i);
    model_edge(wr, rd, clr, d);
    #1;
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    clear_i = 1'b0;
  endtask

  task automatic test_reset();
    preset_ni = 1'b0;
    #3;
    checks++;
    if ({status_o, count_o, data_o} !== {8'h05, 5'd0, 8'h00}) begin
      errors++;
      $display("FAIL reset_initial status=%h count=%0d data=%h want 05/0/00",
               status_o, count_o, data_o);
    end
    @(negedge pclk_i);
    preset_ni = 1'b1;
    model_reset();
    // Build up traffic, then assert reset between clock edges.
    for (int i = 0; i < 6; i++) step(1'b1, (i == 4), 1'b0, 8'(i + 8'h20));
    #2;
    preset_ni = 1'b0;
    #1;
    checks++;
    if ({status_o, count_o, data_o} !== {8'h05, 5'd0, 8'h00}) begin
      errors++;
      $display("FAIL reset_async status=%h count=%0d data=%h want 05/0/00",
               status_o, count_o, data_o);
    end
    model_reset();
    @(negedge pclk_i);
    preset_ni = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_fill_wrap_overflow();
    logic [7:0] last;
    // Offset the pointers first so the fill crosses the wrap point.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'hE0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'(i));
      checks++;
      if ({status_o, count_o} !== {exp_status(), 5'(q.size())}) begin
        errors++;
        $display("FAIL fill_%0d status=%h count=%0d want %h/%0d",
                 i, status_o, count_o, exp_status(), q.size());
      end
    end
    checks++;
    if (status_o !== 8'h0A) begin
      errors++;
      $display("FAIL full_status status=%h want 0a", status_o);
    end
    step(1'b1, 1'b0, 1'b0, 8'hAA);
    checks++;
    if ({status_o, count_o} !== {8'h1A, 5'd16}) begin
      errors++;
      $display("FAIL overflow status=%h count=%0d want 1a/16", status_o, count_o);
    end
    for (int i = 1; i <= 16; i++) begin
`ifdef I2C_FIFO_FWFT_EN
      checks++;
      if (data_o !== 8'(i)) begin
        errors++;
        $display("FAIL drain_%0d data=%h want %h", i, data_o, 8'(i));
      end
      step(1'b0, 1'b1, 1'b0, 8'h00);
`else
      step(1'b0, 1'b1, 1'b0, 8'h00);
      checks++;
      if (data_o !== 8'(i)) begin
        errors++;
        $display("FAIL drain_%0d data=%h want %h", i, data_o, 8'(i));
      end
`endif
    end
    last = data_o;
    step(1'b0, 1'b1, 1'b0, 8'h00);
    checks++;
    if ({data_o, status_o[5], count_o} !== {last, 1'b1, 5'd0}) begin
      errors++;
      $display("FAIL underflow data=%h uf=%b count=%0d want %h/1/0",
               data_o, status_o[5], count_o, last);
    end
    step(1'b0, 1'b0, 1'b1, 8'h00);
    checks++;
    if ({status_o, count_o, data_o} !== {8'h05, 5'd0, 8'h00}) begin
      errors++;
      $display("FAIL clear status=%h count=%0d data=%h want 05/0/00",
               status_o, count_o, data_o);
    end
    $display("test_fill_wrap_overflow done");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)));
    step(1'b1, 1'b1, 1'b0, 8'h55);
    checks++;
    if ({count_o, status_o[4], data_o} !== {5'd16, 1'b0, exp_data()}) begin
      errors++;
      $display("FAIL push_pop_full count=%0d ov=%b data=%h want 16/0/%h",
               count_o, status_o[4], data_o, exp_data());
    end
    for (int i = 0; i < 16; i++) begin
`ifdef I2C_FIFO_FWFT_EN
      if (i == 15) begin
        checks++;
        if (data_o !== 8'h55) begin
          errors++;
          $display("FAIL last_word data=%h want 55", data_o);
        end
      end
`endif
      step(1'b0, 1'b1, 1'b0, 8'h00);
      checks++;
      if ({status_o, count_o, data_o} !== {exp_status(), 5'(q.size()), exp_data()}) begin
        errors++;
        $display("FAIL b2b_drain_%0d status=%h count=%0d data=%h want %h/%0d/%h",
                 i, status_o, count_o, data_o, exp_status(), q.size(), exp_data());
      end
    end
`ifndef I2C_FIFO_FWFT_EN
    checks++;
    if (data_o !== 8'h55) begin
      errors++;
      $display("FAIL last_word data=%h want 55", data_o);
    end
`endif
    $display("test_back_to_back done");
  endtask

  task automatic test_thresholds();
    step(1'b0, 1'b0, 1'b1, 8'h00);
    for (int n = 1; n <= 14; n++) begin
      step(1'b1, 1'b0, 1'b0, 8'(n + 8'h40));
      if (n == 2 || n == 3) begin
        checks++;
        if (status_o[2] !== (n == 2)) begin
          errors++;
          $display("FAIL almost_empty_at_%0d ae=%b want %b", n, status_o[2], (n == 2));
        end
      end
      if (n == 13 || n == 14) begin
        checks++;
        if (status_o[3] !== (n == 14)) begin
          errors++;
          $display("FAIL almost_full_at_%0d af=%b want %b", n, status_o[3], (n == 14));
        end
      end
    end
    step(1'b0, 1'b0, 1'b1, 8'h00);
    $display("test_thresholds done");
  endtask

  task automatic test_read_mode();
    step(1'b1, 1'b0, 1'b0, 8'h3C);
`ifdef I2C_FIFO_FWFT_EN
    checks++;
    if (data_o !== 8'h3C) begin
      errors++;
      $display("FAIL fwft_head data=%h want 3c", data_o);
    end
    step(1'b0, 1'b1, 1'b0, 8'h00);
    checks++;
    if ({data_o, status_o[0]} !== {8'h00, 1'b1}) begin
      errors++;
      $display("FAIL fwft_pop data=%h empty=%b want 00/1", data_o, status_o[0]);
    end
`else
    checks++;
    if ({data_o, status_o[0]} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reg_no_pop data=%h empty=%b want 00/0", data_o, status_o[0]);
    end
    step(1'b0, 1'b1, 1'b0, 8'h00);
    checks++;
    if ({data_o, status_o[0]} !== {8'h3C, 1'b1}) begin
      errors++;
      $display("FAIL reg_pop data=%h empty=%b want 3c/1", data_o, status_o[0]);
    end
`endif
    // Push and pop together on an empty FIFO: pop underflows, word stays.
    step(1'b1, 1'b1, 1'b0, 8'h77);
    checks++;
    if ({status_o, count_o, data_o} !== {exp_status(), 5'(q.size()), exp_data()}) begin
      errors++;
      $display("FAIL push_pop_empty status=%h count=%0d data=%h want %h/%0d/%h",
               status_o, count_o, data_o, exp_status(), q.size(), exp_data());
    end
    step(1'b0, 1'b0, 1'b1, 8'h00);
    $display("test_read_mode done");
  endtask

  task automatic test_random();
    int wr_pct;
    int rd_pct;
    for (int i = 0; i < 600; i++) begin
      wr_pct = ((i / 100) % 2 == 0) ? 80 : 25;
      rd_pct = ((i / 100) % 2 == 0) ? 25 : 80;
      step(($urandom_range(0, 99) < wr_pct), ($urandom_range(0, 99) < rd_pct),
           ($urandom_range(0, 199) == 0), 8'($urandom_range(0, 255)));
      checks++;
      if ({status_o, count_o, data_o} !== {exp_status(), 5'(q.size()), exp_data()}) begin
        errors++;
        $display("FAIL random_%0d status=%h count=%0d data=%h want %h/%0d/%h",
                 i, status_o, count_o, data_o, exp_status(), q.size(), exp_data());
      end
    end
    $display("test_random done");
  endtask

  initial begin
    clear_i = 1'b0;
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    data_i  = 8'h00;
    model_reset();
    test_reset();
    test_fill_wrap_overflow();
    test_back_to_back();
    test_thresholds();
    test_read_mode();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
